// File: rtl/tryte_organiser_if.sv
// Byte-in / word-out bus of the tryte organiser.
// master: the organiser itself; slave: the reader/consumer side.
interface tryte_organiser_if #(
  parameter int FIFO_DEPTH = 16
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic          byte_valid;
  logic [7:0]    byte_data;
  logic          read_signal;
  logic          trytes_rec;
  logic          ack_tryte;
  logic          word_valid;
  logic [23:0]   word_data;
  logic          word_ready;
  logic [CW-1:0] fifo_count;
  logic          overflow;
  logic          frame_err;

  modport master (
    input  byte_valid, byte_data, ack_tryte, word_ready,
    output read_signal, trytes_rec, word_valid, word_data, fifo_count, overflow, frame_err
  );

  modport slave (
    output byte_valid, byte_data, ack_tryte, word_ready,
    input  read_signal, trytes_rec, word_valid, word_data, fifo_count, overflow, frame_err
  );
endinterface

// File: rtl/tryte_organiser.sv
// Packs UART bytes into 24-bit trytes, queues them in a first-word
// fall-through FIFO and runs the 'X' handshake with the reader.
// Optional build macro: ORG_TIMEOUT_EN -- discard a stalled partial tryte
// after TIMEOUT_CYC idle cycles and flag frame_err.
module tryte_organiser #(
  parameter int FIFO_DEPTH  = 16,
  parameter int TIMEOUT_CYC = 1000000
) (
  input logic               m_axi_aclk,
  input logic               m_axi_aresetn,
  tryte_organiser_if.master bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  localparam logic [1:0] COLLECT   = 2'd0;
  localparam logic [1:0] PUSH      = 2'd1;
  localparam logic [1:0] HANDSHAKE = 2'd2;

  logic          run_q, run_d;
  logic [1:0]    state_q, state_d;
  logic [1:0]    byte_cnt_q, byte_cnt_d;
  logic [23:0]   word_asm_q, word_asm_d;
  logic          skid_full_q, skid_full_d;
  logic [7:0]    skid_data_q, skid_data_d;
  logic          trytes_rec_q, trytes_rec_d;
  logic          overflow_q, overflow_d;
  logic          frame_err_q, frame_err_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [23:0]   head_q, head_d;
  logic [23:0]   mem [FIFO_DEPTH];

  logic          in_valid;
  logic [7:0]    in_byte;
  logic          accept;
  logic          push, pop, fifo_full;
  logic [AW-1:0] rd_next;
  logic          timeout;

`ifdef ORG_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] idle_q, idle_d;

  // Idle counter: runs only while a partial tryte waits in COLLECT
  always_comb begin
    idle_d  = idle_q;
    timeout = 1'b0;
    if (accept) begin
      idle_d = '0;
    end else if (state_q == COLLECT && byte_cnt_q != 2'd0) begin
      if (idle_q == TW'(TIMEOUT_CYC - 1)) begin
        timeout = 1'b1;
        idle_d  = '0;
      end else begin
        idle_d = idle_q + 1'b1;
      end
    end
  end

  // Idle counter register
  always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
    if (!m_axi_aresetn) idle_q <= '0;
    else                idle_q <= idle_d;
  end
`else
  // Partial trytes are held indefinitely; the comparison is constant false
  assign timeout = (TIMEOUT_CYC < 0);
`endif

  // Byte intake, tryte assembly, skid buffering and handshake sequencing
  always_comb begin
    run_d        = 1'b1;
    state_d      = state_q;
    byte_cnt_d   = byte_cnt_q;
    word_asm_d   = word_asm_q;
    skid_full_d  = skid_full_q;
    skid_data_d  = skid_data_q;
    trytes_rec_d = trytes_rec_q;
    overflow_d   = overflow_q;
    frame_err_d  = frame_err_q;

    // The skid byte is older than any byte arriving now, so it goes first
    in_valid = skid_full_q | bus.byte_valid;
    in_byte  = skid_full_q ? skid_data_q : bus.byte_data;
    accept   = (state_q == COLLECT) && in_valid;

    case (state_q)
      COLLECT: begin
        if (skid_full_q) begin
          // Skid drains into the word; a simultaneous new byte refills it
          skid_full_d = bus.byte_valid;
          skid_data_d = bus.byte_valid ? bus.byte_data : skid_data_q;
        end
        if (accept) begin
          case (byte_cnt_q)
            2'd0:    word_asm_d[23:16] = in_byte;
            2'd1:    word_asm_d[15:8]  = in_byte;
            default: word_asm_d[7:0]   = in_byte;
          endcase
          if (byte_cnt_q == 2'd2) begin
            byte_cnt_d = 2'd0;
            state_d    = PUSH;
          end else begin
            byte_cnt_d = byte_cnt_q + 2'd1;
          end
        end else if (timeout) begin
          byte_cnt_d  = 2'd0;
          word_asm_d  = '0;
          frame_err_d = 1'b1;
        end
      end
      PUSH: begin
        // Only reachable from an in-flight poll racing a full FIFO
        if (!push) overflow_d = 1'b1;
        trytes_rec_d = 1'b1;
        state_d      = HANDSHAKE;
      end
      HANDSHAKE: begin
        if (bus.ack_tryte) begin
          trytes_rec_d = 1'b0;
          state_d      = COLLECT;
        end
      end
      default: state_d = COLLECT;
    endcase

    // Outside COLLECT bytes are parked; a second one has nowhere to go
    if (state_q != COLLECT && bus.byte_valid) begin
      if (skid_full_q) begin
        overflow_d = 1'b1;
      end else begin
        skid_full_d = 1'b1;
        skid_data_d = bus.byte_data;
      end
    end
  end

  // FIFO pointer, occupancy and fall-through head computation
  always_comb begin
    fifo_full = (count_q == CW'(FIFO_DEPTH));
    pop       = bus.word_ready && (count_q != '0);
    push      = (state_q == PUSH) && (!fifo_full || pop);
    rd_next   = rd_ptr_q + AW'(1);
    wr_ptr_d  = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d  = pop ? rd_next : rd_ptr_q;
    count_d   = count_q;
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (pop && !push) count_d = count_q - CW'(1);
    // Head register keeps the last word visible once the FIFO empties
    head_d = head_q;
    if (count_q == '0) begin
      if (push) head_d = word_asm_q;
    end else if (pop) begin
      if (count_q != CW'(1)) head_d = mem[rd_next];
      else if (push)         head_d = word_asm_q;
    end
  end

  // Control and status registers
  always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
    if (!m_axi_aresetn) begin
      run_q        <= 1'b0;
      state_q      <= COLLECT;
      byte_cnt_q   <= 2'd0;
      word_asm_q   <= '0;
      skid_full_q  <= 1'b0;
      skid_data_q  <= '0;
      trytes_rec_q <= 1'b0;
      overflow_q   <= 1'b0;
      frame_err_q  <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      head_q       <= '0;
    end else begin
      run_q        <= run_d;
      state_q      <= state_d;
      byte_cnt_q   <= byte_cnt_d;
      word_asm_q   <= word_asm_d;
      skid_full_q  <= skid_full_d;
      skid_data_q  <= skid_data_d;
      trytes_rec_q <= trytes_rec_d;
      overflow_q   <= overflow_d;
      frame_err_q  <= frame_err_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      head_q       <= head_d;
    end
  end

  // Word storage; contents are never read before being written
  always_ff @(posedge m_axi_aclk) begin
    if (push) mem[wr_ptr_q] <= word_asm_q;
  end

  assign bus.read_signal = run_q && (state_q == COLLECT) && !skid_full_q && !fifo_full;
  assign bus.trytes_rec  = trytes_rec_q;
  assign bus.word_valid  = (count_q != '0);
  assign bus.word_data   = head_q;
  assign bus.fifo_count  = count_q;
  assign bus.overflow    = overflow_q;
  assign bus.frame_err   = frame_err_q;
endmodule

// File: tb/tb_tryte_organiser.sv
// Directed bench for tryte_organiser: inputs change and outputs are
// sampled on the falling clock edge.
module tb_tryte_organiser;
  localparam int DEPTH = 16;
  localparam int TOUT  = 100;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;

  tryte_organiser_if #(.FIFO_DEPTH(DEPTH)) bus ();

  tryte_organiser #(
    .FIFO_DEPTH (DEPTH),
    .TIMEOUT_CYC(TOUT)
  ) dut (
    .m_axi_aclk   (clk),
    .m_axi_aresetn(rst_n),
    .bus          (bus)
  );

  always #5 clk = ~clk;

  // One-cycle byte pulse starting at the current falling edge
  task automatic send_byte(input logic [7:0] b);
    bus.byte_valid = 1'b1;
    bus.byte_data  = b;
    @(negedge clk);
    bus.byte_valid = 1'b0;
  endtask

  task automatic ack();
    bus.ack_tryte = 1'b1;
    @(negedge clk);
    bus.ack_tryte = 1'b0;
  endtask

  task automatic pop_one();
    bus.word_ready = 1'b1;
    @(negedge clk);
    bus.word_ready = 1'b0;
  endtask

  task automatic send_tryte(input logic [23:0] w);
    send_byte(w[23:16]);
    send_byte(w[15:8]);
    send_byte(w[7:0]);
    @(negedge clk);
    ack();
    $display("[TB] tryte %06h sent and acknowledged", w);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    tests++;
    if ({bus.read_signal, bus.trytes_rec, bus.word_valid, bus.word_data, bus.fifo_count,
         bus.overflow, bus.frame_err} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got rs=%b tr=%b wv=%b wd=%06h cnt=%0d ov=%b fe=%b, expected all 0",
               bus.read_signal, bus.trytes_rec, bus.word_valid, bus.word_data, bus.fifo_count,
               bus.overflow, bus.frame_err);
    end
    rst_n = 1'b1;
    #1;
    tests++;
    if (bus.read_signal !== 1'b0) begin
      fails++;
      $display("FAIL reset_release_rs: got %b expected 0", bus.read_signal);
    end
    @(negedge clk);
    tests++;
    if (bus.read_signal !== 1'b1) begin
      fails++;
      $display("FAIL reset_run_rs: got %b expected 1", bus.read_signal);
    end
  endtask

  task automatic test_single_tryte();
    send_byte(8'h12);
    send_byte(8'h34);
    send_byte(8'h56);
    // This ack lands while the word is still being pushed and must be ignored
    ack();
    tests++;
    if (bus.word_data !== 24'h123456 || bus.word_valid !== 1'b1 || bus.fifo_count !== 5'd1) begin
      fails++;
      $display("FAIL single_word: got wd=%06h wv=%b cnt=%0d expected 123456 1 1",
               bus.word_data, bus.word_valid, bus.fifo_count);
    end
    tests++;
    if (bus.trytes_rec !== 1'b1) begin
      fails++;
      $display("FAIL early_ack_ignored: trytes_rec got %b expected 1", bus.trytes_rec);
    end
    ack();
    tests++;
    if (bus.trytes_rec !== 1'b0 || bus.read_signal !== 1'b1) begin
      fails++;
      $display("FAIL ack_release: got tr=%b rs=%b expected 0 1", bus.trytes_rec, bus.read_signal);
    end
    pop_one();
    tests++;
    if (bus.word_valid !== 1'b0 || bus.fifo_count !== 5'd0 || bus.word_data !== 24'h123456) begin
      fails++;
      $display("FAIL empty_hold: got wv=%b cnt=%0d wd=%06h expected 0 0 123456",
               bus.word_valid, bus.fifo_count, bus.word_data);
    end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 16; i++) send_tryte(24'(i));
    tests++;
    if (bus.fifo_count !== 5'd16 || bus.read_signal !== 1'b0 || bus.word_data !== 24'h000000) begin
      fails++;
      $display("FAIL fifo_full: got cnt=%0d rs=%b wd=%06h expected 16 0 000000",
               bus.fifo_count, bus.read_signal, bus.word_data);
    end
    pop_one();
    tests++;
    if (bus.fifo_count !== 5'd15 || bus.read_signal !== 1'b1) begin
      fails++;
      $display("FAIL full_pop: got cnt=%0d rs=%b expected 15 1", bus.fifo_count, bus.read_signal);
    end
    for (int i = 1; i < 16; i++) begin
      tests++;
      if (bus.word_data !== 24'(i)) begin
        fails++;
        $display("FAIL fill_order[%0d]: got %06h expected %06h", i, bus.word_data, 24'(i));
      end
      pop_one();
    end
    tests++;
    if (bus.word_valid !== 1'b0 || bus.fifo_count !== 5'd0) begin
      fails++;
      $display("FAIL fill_drained: got wv=%b cnt=%0d expected 0 0", bus.word_valid, bus.fifo_count);
    end
  endtask

  task automatic test_skid_overflow();
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    @(negedge clk);
    send_byte(8'hAA);
    tests++;
    if (bus.read_signal !== 1'b0 || bus.overflow !== 1'b0) begin
      fails++;
      $display("FAIL skid_hold: got rs=%b ov=%b expected 0 0", bus.read_signal, bus.overflow);
    end
    send_byte(8'hBB);
    tests++;
    if (bus.overflow !== 1'b1 || bus.trytes_rec !== 1'b1) begin
      fails++;
      $display("FAIL skid_overflow: got ov=%b tr=%b expected 1 1", bus.overflow, bus.trytes_rec);
    end
    ack();
    send_byte(8'hCC);
    send_byte(8'hDD);
    repeat (2) @(negedge clk);
    tests++;
    if (bus.trytes_rec !== 1'b1 || bus.fifo_count !== 5'd2 || bus.word_data !== 24'h112233) begin
      fails++;
      $display("FAIL skid_second_word: got tr=%b cnt=%0d wd=%06h expected 1 2 112233",
               bus.trytes_rec, bus.fifo_count, bus.word_data);
    end
    ack();
    pop_one();
    tests++;
    if (bus.word_data !== 24'hAACCDD || bus.overflow !== 1'b1) begin
      fails++;
      $display("FAIL skid_word: got wd=%06h ov=%b expected AACCDD 1", bus.word_data, bus.overflow);
    end
    pop_one();
  endtask

  task automatic test_push_pop();
    for (int i = 0; i < 5; i++) send_tryte(24'hA00000 + 24'(i));
    tests++;
    if (bus.fifo_count !== 5'd5 || bus.word_data !== 24'hA00000) begin
      fails++;
      $display("FAIL pp_setup: got cnt=%0d wd=%06h expected 5 A00000", bus.fifo_count, bus.word_data);
    end
    send_byte(8'hA0);
    send_byte(8'h00);
    send_byte(8'h05);
    // The next rising edge writes the new word; pop on that same edge
    pop_one();
    tests++;
    if (bus.fifo_count !== 5'd5 || bus.word_data !== 24'hA00001 || bus.trytes_rec !== 1'b1) begin
      fails++;
      $display("FAIL push_pop: got cnt=%0d wd=%06h tr=%b expected 5 A00001 1",
               bus.fifo_count, bus.word_data, bus.trytes_rec);
    end
    ack();
    for (int i = 1; i < 6; i++) begin
      tests++;
      if (bus.word_data !== 24'hA00000 + 24'(i)) begin
        fails++;
        $display("FAIL pp_order[%0d]: got %06h expected %06h", i, bus.word_data, 24'hA00000 + 24'(i));
      end
      pop_one();
    end
  endtask

  task automatic test_timeout();
    send_byte(8'hEE);
    send_byte(8'hFF);
`ifdef ORG_TIMEOUT_EN
    repeat (TOUT - 1) @(negedge clk);
    tests++;
    if (bus.frame_err !== 1'b0) begin
      fails++;
      $display("FAIL timeout_early: frame_err got %b expected 0", bus.frame_err);
    end
    @(negedge clk);
    tests++;
    if (bus.frame_err !== 1'b1) begin
      fails++;
      $display("FAIL timeout_fire: frame_err got %b expected 1", bus.frame_err);
    end
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h03);
    @(negedge clk);
    tests++;
    if (bus.word_data !== 24'h010203 || bus.trytes_rec !== 1'b1) begin
      fails++;
      $display("FAIL timeout_fresh_word: got wd=%06h tr=%b expected 010203 1",
               bus.word_data, bus.trytes_rec);
    end
`else
    repeat (TOUT + 20) @(negedge clk);
    tests++;
    if (bus.frame_err !== 1'b0) begin
      fails++;
      $display("FAIL no_timeout: frame_err got %b expected 0", bus.frame_err);
    end
    send_byte(8'h03);
    @(negedge clk);
    tests++;
    if (bus.word_data !== 24'hEEFF03 || bus.trytes_rec !== 1'b1) begin
      fails++;
      $display("FAIL held_partial: got wd=%06h tr=%b expected EEFF03 1",
               bus.word_data, bus.trytes_rec);
    end
`endif
    ack();
    pop_one();
  endtask

  task automatic test_reset_mid();
    send_byte(8'h77);
    send_byte(8'h88);
    send_byte(8'h99);
    @(negedge clk);
    send_byte(8'h55);
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if ({bus.read_signal, bus.trytes_rec, bus.word_valid, bus.word_data, bus.fifo_count,
         bus.overflow, bus.frame_err} !== '0) begin
      fails++;
      $display("FAIL midreset_outputs: got rs=%b tr=%b wv=%b wd=%06h cnt=%0d ov=%b fe=%b, expected all 0",
               bus.read_signal, bus.trytes_rec, bus.word_valid, bus.word_data, bus.fifo_count,
               bus.overflow, bus.frame_err);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    tests++;
    if (bus.read_signal !== 1'b0) begin
      fails++;
      $display("FAIL midreset_release_rs: got %b expected 0", bus.read_signal);
    end
    @(negedge clk);
    tests++;
    if (bus.read_signal !== 1'b1) begin
      fails++;
      $display("FAIL midreset_run_rs: got %b expected 1", bus.read_signal);
    end
    send_byte(8'h44);
    send_byte(8'h55);
    send_byte(8'h66);
    @(negedge clk);
    tests++;
    if (bus.word_data !== 24'h445566 || bus.fifo_count !== 5'd1) begin
      fails++;
      $display("FAIL midreset_clean_word: got wd=%06h cnt=%0d expected 445566 1",
               bus.word_data, bus.fifo_count);
    end
    ack();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;
    bus.ack_tryte  = 1'b0;
    bus.word_ready = 1'b0;
    test_reset();
    test_single_tryte();
    test_fill();
    test_skid_overflow();
    test_push_pop();
    test_timeout();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
